// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: fifo read port plus serial-line signals of the UART transmitter.
// The transmitter connects through the master modport. The fifo and line side connects through slave.
interface uart_tx_fifo_if #(
    parameter int BITWIDTH = 8
);
    logic [BITWIDTH-1:0] rport_i;
    logic                empty_i;
    logic                rdeq_o;
    logic                cts_i;
    logic                txd_o;
    logic                busy_o;

    modport master (
        input  rport_i,
        input  empty_i,
        input  cts_i,
        output rdeq_o,
        output txd_o,
        output busy_o
    );

    modport slave (
        output rport_i,
        output empty_i,
        output cts_i,
        input  rdeq_o,
        input  txd_o,
        input  busy_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: drains a fifo and shifts each element out as a UART frame.
// Each frame is a start bit, then the data bits LSB first, then the stop bits.
// The clear-to-send input is sampled only when a frame is about to start.
module uart_tx_fifo #(
    parameter int BITWIDTH = 8,
    parameter int DIVISOR  = 417,
    parameter int STOPBITS = 1
) (
    input  logic           clk6x,
    input  logic           reset,
    uart_tx_fifo_if.master bus
);
    localparam int BAUD_W = $clog2(DIVISOR);
    localparam int BIT_W  = $clog2(BITWIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVISOR - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(BITWIDTH - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOPBITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]          state;
    logic [BITWIDTH-1:0] shift;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic                txd;
    logic                rdeq;
    logic                busy;

    logic start_ok;
    logic baud_last;
    logic launch;

    assign start_ok  = !bus.empty_i && bus.cts_i;
    assign baud_last = (baud_cnt == BAUD_LAST);
    // A frame launches from IDLE. It also launches from the final stop cycle, so back-to-back frames have no gap.
    assign launch    = start_ok &&
                       ((state == IDLE) ||
                        ((state == STOP) && baud_last && (bit_cnt == LAST_STOP)));

    assign bus.txd_o  = txd;
    assign bus.rdeq_o = rdeq;
    assign bus.busy_o = busy;

    // Frame sequencer: it latches the character, paces each bit time and drives the registered outputs.
    always_ff @(posedge clk6x or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
            rdeq     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rdeq <= 1'b0;
            if (launch) begin
                state    <= START;
                shift    <= bus.rport_i;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                txd      <= 1'b0;
                rdeq     <= 1'b1;
                busy     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        txd  <= 1'b1;
                        busy <= 1'b0;
                    end
                    START: begin
                        if (baud_last) begin
                            baud_cnt <= '0;
                            state    <= DATA;
                            txd      <= shift[0];
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (baud_last) begin
                            baud_cnt <= '0;
                            shift    <= shift >> 1;
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
                                state   <= STOP;
                                txd     <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                txd     <= shift[1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (baud_last) begin
                            baud_cnt <= '0;
                            if (bit_cnt == LAST_STOP) begin
                                bit_cnt <= '0;
                                state   <= IDLE;
                                busy    <= 1'b0;
                                txd     <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        txd   <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo.
// It uses a frame-position reference model, a bench-side fifo and a line receiver.
module tb_uart_tx_fifo;
    localparam int BITWIDTH = 8;
    localparam int DIVISOR  = 4;
    localparam int STOPBITS = 1;
    localparam int FRAME    = (1 + BITWIDTH + STOPBITS) * DIVISOR;
    localparam int DEPTH    = 4;

    logic clk6x = 1'b0;
    logic reset = 1'b1;

    uart_tx_fifo_if #(.BITWIDTH(BITWIDTH)) bus ();

    uart_tx_fifo #(
        .BITWIDTH(BITWIDTH),
        .DIVISOR (DIVISOR),
        .STOPBITS(STOPBITS)
    ) dut (
        .clk6x(clk6x),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk6x = ~clk6x;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Bench-side fifo: only the stimulus writes wr_ptr, and only the line process writes rd_ptr.
    logic [7:0] fmem [16];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign bus.empty_i = (wr_ptr == rd_ptr);
    assign bus.rport_i = fmem[rd_ptr[3:0]];

    // Reference model: whether a frame is active, the position in that frame, and the character.
    logic       m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_byte   = 8'h00;

    int         pulse_cyc [$];
    logic [7:0] rx_q [$];
    logic       rx_busy = 1'b0;
    int         rx_cnt  = 0;
    logic [7:0] rx_byte = 8'h00;

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic exp_level(input logic [7:0] b, input int p);
        int idx;
        idx = p / DIVISOR;
        if (idx == 0) return 1'b0;
        if (idx <= BITWIDTH) return b[idx-1];
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] d);
        fmem[wr_ptr[3:0]] = d;
        wr_ptr++;
    endtask

    task automatic wait_rdeq(input int bound, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk6x);
            if (bus.rdeq_o) begin
                seen = 1'b1;
                break;
            end
        end
        check_output(name, int'(seen), 1);
    endtask

    // On each edge, advance through the current frame or decide whether the next frame starts.
    always @(posedge clk6x or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else begin
            cyc++;
            if (m_active && m_pos < FRAME - 1) begin
                m_pos++;
            end else if (!bus.empty_i && bus.cts_i) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_byte   = bus.rport_i;
            end else begin
                m_active = 1'b0;
                m_pos    = 0;
            end
        end
    end

    // Between edges: compare the outputs against the model, dequeue on rdeq, and decode the line.
    always @(negedge clk6x) begin
        if (!reset) begin
            check_output("txd", int'(bus.txd_o),
                         int'(m_active ? exp_level(m_byte, m_pos) : 1'b1));
            check_output("busy", int'(bus.busy_o), int'(m_active));
            check_output("rdeq", int'(bus.rdeq_o), int'(m_active && m_pos == 0));
            if (bus.rdeq_o) begin
                pulse_cyc.push_back(cyc);
                check_output("rdeq_nonempty", int'(wr_ptr != rd_ptr), 1);
                if (wr_ptr != rd_ptr) rd_ptr++;
            end
            if (!rx_busy) begin
                if (bus.txd_o == 1'b0) begin
                    rx_busy = 1'b1;
                    rx_cnt  = 0;
                end
            end else begin
                rx_cnt++;
                for (int i = 0; i < BITWIDTH; i++)
                    if (rx_cnt == DIVISOR * (i + 1) + DIVISOR / 2) rx_byte[i] = bus.txd_o;
                if (rx_cnt == DIVISOR * (BITWIDTH + 1) + DIVISOR / 2) begin
                    check_output("stop_bit", int'(bus.txd_o), 1);
                    rx_q.push_back(rx_byte);
                    rx_busy = 1'b0;
                end
            end
        end else begin
            rx_busy = 1'b0;
        end
    end

    // Watchdog: if the run stops making progress, it ends instead of hanging.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        logic [7:0] lvl_12 [10];
        logic [7:0] exp_rx [15];
        int         n;
        lvl_12 = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
        exp_rx = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                   8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        bus.cts_i = 1'b0;
        reset     = 1'b1;

        // Hold reset, then release it with the fifo empty.
        repeat (4) begin
            @(negedge clk6x);
            check_output("reset_txd", int'(bus.txd_o), 1);
            check_output("reset_busy", int'(bus.busy_o), 0);
            check_output("reset_rdeq", int'(bus.rdeq_o), 0);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk6x);

        // Assert reset mid-frame: the line must go back high within the same cycle.
        bus.cts_i = 1'b1;
        push(8'hA5);
        repeat (12) @(negedge clk6x);
        @(posedge clk6x);
        #2 reset = 1'b1;
        #1;
        check_output("midreset_txd", int'(bus.txd_o), 1);
        check_output("midreset_busy", int'(bus.busy_o), 0);
        @(negedge clk6x);
        @(negedge clk6x);
        reset = 1'b0;
        repeat (10) @(negedge clk6x);
        check_output("after_reset_fifo", wr_ptr - rd_ptr, 0);

        // Single character 8'h12, with the line levels written out literally.
        push(8'h12);
        wait_rdeq(10, "wait_12");
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < DIVISOR; c++) begin
                check_output("frame12_txd", int'(bus.txd_o), int'(lvl_12[b]));
                @(negedge clk6x);
            end
        end
        check_output("frame12_busy_end", int'(bus.busy_o), 0);

        // Fill the fifo to four entries while CTS is low, then let the frames run back to back.
        bus.cts_i = 1'b0;
        push(8'h34); push(8'h56); push(8'h78); push(8'h9A);
        check_output("fifo_full", wr_ptr - rd_ptr, DEPTH);
        @(negedge clk6x);
        bus.cts_i = 1'b1;
        wait_rdeq(10, "wait_burst");
        repeat (121) @(negedge clk6x);
        check_output("burst_empty", int'(bus.empty_i), 1);
        repeat (45) @(negedge clk6x);
        n = pulse_cyc.size();
        for (int k = n - 3; k < n; k++)
            check_output("pulse_spacing", pulse_cyc[k] - pulse_cyc[k-1], 40);

        // With CTS low, a queued character must wait.
        bus.cts_i = 1'b0;
        push(8'hBC);
        repeat (10) begin
            @(negedge clk6x);
            check_output("cts_hold_rdeq", int'(bus.rdeq_o), 0);
            check_output("cts_hold_txd", int'(bus.txd_o), 1);
        end
        bus.cts_i = 1'b1;
        @(negedge clk6x);
        check_output("cts_start_rdeq", int'(bus.rdeq_o), 1);
        repeat (45) @(negedge clk6x);

        // Drop CTS mid-frame: 8'hDE still completes and 8'hF0 waits.
        push(8'hDE); push(8'hF0);
        wait_rdeq(10, "wait_DE");
        repeat (10) @(negedge clk6x);
        bus.cts_i = 1'b0;
        repeat (60) @(negedge clk6x);
        check_output("cts_drop_busy", int'(bus.busy_o), 0);
        check_output("cts_drop_fifo", wr_ptr - rd_ptr, 1);
        bus.cts_i = 1'b1;
        wait_rdeq(5, "wait_F0");
        repeat (45) @(negedge clk6x);

        // Write while the transmitter drains: one character every 20 cycles.
        for (int k = 0; k < 7; k++) begin
            check_output("fifo_room", int'((wr_ptr - rd_ptr) < DEPTH), 1);
            push(8'h11 + 8'(k));
            repeat (20) @(negedge clk6x);
        end
        begin
            bit idle;
            idle = 1'b0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk6x);
                if (!bus.busy_o && bus.empty_i) begin
                    idle = 1'b1;
                    break;
                end
            end
            check_output("drain_idle", int'(idle), 1);
        end
        repeat (5) @(negedge clk6x);

        // The decoded line must carry every character in order.
        check_output("rx_count", rx_q.size(), 15);
        for (int i = 0; i < 15; i++)
            check_output("rx_byte", (i < rx_q.size()) ? int'(rx_q[i]) : -1, int'(exp_rx[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
